// File: rtl/serial_adder_if.sv
// Start/operand/result bundle for serial_adder.
// Carries ovf only when SERIAL_ADDER_OVF_EN is defined.
`timescale 1ns/1ps
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one bit pair per RUN cycle, LSB first, result registered on completion.
// Optional two's-complement overflow output enabled by SERIAL_ADDER_OVF_EN.
`timescale 1ns/1ps
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Full adder built from two half adders plus an OR.
  logic ha1_s, ha1_c, fa_s, ha2_c, fa_c;
  assign ha1_s = a_q[0] ^ b_q[0];
  assign ha1_c = a_q[0] & b_q[0];
  assign fa_s  = ha1_s ^ carry_q;
  assign ha2_c = ha1_s & carry_q;
  assign fa_c  = ha1_c | ha2_c;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          part_d  = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        part_d  = {fa_s, part_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          sum_d   = {fa_s, part_q[WIDTH-1:1]};
          cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB on the final bit.
          ovf_d   = carry_q ^ fa_c;
`endif
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
  assign bus.ovf = ovf_q;
`endif

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vector table, back-to-back, mid-run reset,
// and random operands against an arithmetic reference. Covers ovf when SERIAL_ADDER_OVF_EN is set.
`timescale 1ns/1ps
module tb_serial_adder;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned NumRandom = 3000;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [WIDTH-1:0] exp_prev_sum;
  logic             exp_prev_cout;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned and signed integer sums.
  function automatic void ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic cin, output logic [WIDTH-1:0] s,
                                  output logic co, output logic ov);
    longint u, sv, maxv, minv;
    u    = longint'(a) + longint'(b) + longint'(cin);
    s    = WIDTH'(u);
    co   = u[WIDTH];
    sv   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    maxv = (longint'(1) <<< (WIDTH - 1)) - 1;
    minv = -(longint'(1) <<< (WIDTH - 1));
    ov   = (sv > maxv) || (sv < minv);
  endfunction

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                        input logic [WIDTH-1:0] exp_s, input logic exp_c, input logic exp_o,
                        input string tag);
    int lat = 0;
    int busy_n = 0;
    bit held = 1'b1;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    bus.cin   = 1'($urandom);
    for (int i = 1; i <= 20; i++) begin
      if (bus.done) begin
        lat = i;
        break;
      end
      if (bus.busy) busy_n++;
      if (bus.sum !== exp_prev_sum || bus.cout !== exp_prev_cout) held = 1'b0;
      @(negedge clk);
    end
    check({tag, "_latency"}, lat, 9);
    check({tag, "_busy_cycles"}, busy_n, WIDTH);
    check({tag, "_held_during_run"}, held, 1'b1);
    check({tag, "_busy_at_done"}, bus.busy, 1'b0);
    check({tag, "_sum"}, bus.sum, exp_s);
    check({tag, "_cout"}, bus.cout, exp_c);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, bus.ovf, exp_o);
`else
    if (exp_o === 1'bx) $display("note: ovf expectation unknown for %s", tag);
`endif
    exp_prev_sum  = exp_s;
    exp_prev_cout = exp_c;
  endtask

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  vec_t vecs[7];

  logic [WIDTH-1:0] opa[41];
  logic [WIDTH-1:0] opb[41];
  logic             opc[41];

  initial begin
    logic [WIDTH-1:0] ra, rb, rs;
    logic             rc, rco, rov;
    int               dones;

    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    exp_prev_sum  = '0;
    exp_prev_cout = 1'b0;
    #1;
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_sum", bus.sum, '0);
    check("reset_cout", bus.cout, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table; first start right after reset release must be accepted.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf,
             $sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d_done_single", i), bus.done, 1'b0);
      check($sformatf("vec%0d_idle_busy", i), bus.busy, 1'b0);
    end
    repeat (2) @(negedge clk);

    // start held high with operands changing every cycle: accepts at 0, 9, 18, 27.
    for (int m = 0; m <= 40; m++) begin
      opa[m] = WIDTH'($urandom);
      opb[m] = WIDTH'($urandom);
      opc[m] = 1'($urandom);
    end
    for (int m = 0; m <= 40; m++) begin
      if (m > 0) begin
        check($sformatf("b2b_done_m%0d", m), bus.done, (m % 9 == 0) && (m <= 36));
        check($sformatf("b2b_busy_m%0d", m), bus.busy, (m <= 35) && (m % 9 != 0));
        if ((m % 9 == 0) && (m <= 36)) begin
          ref_add(opa[m-9], opb[m-9], opc[m-9], rs, rco, rov);
          check($sformatf("b2b_sum_m%0d", m), bus.sum, rs);
          check($sformatf("b2b_cout_m%0d", m), bus.cout, rco);
`ifdef SERIAL_ADDER_OVF_EN
          check($sformatf("b2b_ovf_m%0d", m), bus.ovf, rov);
`endif
          exp_prev_sum  = rs;
          exp_prev_cout = rco;
        end
      end
      bus.start = (m <= 27);
      bus.a     = opa[m];
      bus.b     = opb[m];
      bus.cin   = opc[m];
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    // Mid-run reset abort.
    run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, "pre_rst");
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    bus.cin   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_sum", bus.sum, '0);
    check("abort_cout", bus.cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    check("abort_ovf", bus.ovf, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    exp_prev_sum  = '0;
    exp_prev_cout = 1'b0;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op(8'hC3, 8'h5A, 1'b1, 8'h1E, 1'b1, 1'b0, "post_rst");

    // Random operands with random gaps (gap 0 exercises DONE -> RUN directly).
    for (int n = 0; n < NumRandom; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      ref_add(ra, rb, rc, rs, rco, rov);
      run_op(ra, rb, rc, rs, rco, rov, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
